note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_sequencer.sv | 147 ++++++++++++++
 tb/tb_note_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Steps through a fixed eight-note divisor table, one note per TEMPO_CYCLES+1 cycles.
// Define NOTE_SEQ_REVERSE_EN to add a dir input that selects descending playback.
module note_sequencer #(
    parameter int TEMPO_CYCLES = 25000000,
    parameter int DIV_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             loop,
`ifdef NOTE_SEQ_REVERSE_EN
    input  logic             dir,
`endif
    output logic [DIV_W-1:0] divisor,
    output logic             div_load,
    output logic             div_enable,
    output logic [2:0]       note_idx,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = $clog2(TEMPO_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_DONE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] tempo_cnt;
    logic [2:0]       idx_next;
    logic             take_start;
    logic             tempo_tc;
    logic             run_dir;
    logic             start_dir;

    function automatic logic [DIV_W-1:0] note_div(input logic [2:0] i);
        case (i)
            3'd0:    note_div = DIV_W'(47801);
            3'd1:    note_div = DIV_W'(42589);
            3'd2:    note_div = DIV_W'(37936);
            3'd3:    note_div = DIV_W'(35816);
            3'd4:    note_div = DIV_W'(31887);
            3'd5:    note_div = DIV_W'(28409);
            3'd6:    note_div = DIV_W'(25309);
            default: note_div = DIV_W'(23900);
        endcase
    endfunction

`ifdef NOTE_SEQ_REVERSE_EN
    logic dir_q;

    // Direction is captured once per run so toggling dir mid-run has no effect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            dir_q <= 1'b0;
        else if (take_start)
            dir_q <= dir;
    end

    assign run_dir   = dir_q;
    assign start_dir = dir;
`else
    assign run_dir   = 1'b0;
    assign start_dir = 1'b0;
`endif

    // A paused note never reaches its terminal count.
    assign tempo_tc = (state == S_PLAY) && !pause &&
                      (tempo_cnt == CNT_W'(TEMPO_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        idx_next   = note_idx;
        take_start = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (stop) begin
                    state_next = S_IDLE;
                end else if (start) begin
                    state_next = S_LOAD;
                    idx_next   = start_dir ? 3'd7 : 3'd0;
                    take_start = 1'b1;
                end
            end
            S_LOAD: state_next = stop ? S_IDLE : S_PLAY;
            S_PLAY: begin
                if (stop) begin
                    state_next = S_IDLE;
                end else if (tempo_tc) begin
                    if (note_idx == (run_dir ? 3'd0 : 3'd7)) begin
                        if (loop) begin
                            state_next = S_LOAD;
                            idx_next   = run_dir ? 3'd7 : 3'd0;
                        end else begin
                            state_next = S_DONE;
                        end
                    end else begin
                        state_next = S_LOAD;
                        idx_next   = run_dir ? note_idx - 3'd1 : note_idx + 3'd1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        div_load  = 1'b0;
        state_dbg = state;
        case (state)
            S_LOAD:  begin busy = 1'b1; div_load = 1'b1; end
            S_PLAY:  busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Divisor is latched on entry to LOAD so it is already valid while div_load is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            note_idx   <= 3'd0;
            divisor    <= '0;
            tempo_cnt  <= '0;
            div_enable <= 1'b0;
        end else begin
            note_idx   <= idx_next;
            div_enable <= (state_next == S_PLAY) && !((state == S_PLAY) && pause);
            if (state_next == S_LOAD)
                divisor <= note_div(idx_next);
            if (state == S_LOAD)
                tempo_cnt <= '0;
            else if (state == S_PLAY && !pause)
                tempo_cnt <= tempo_tc ? '0 : tempo_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer at TEMPO_CYCLES=4: a vector table plus
// hand-written multi-cycle sequences for looping, pause, stop and reset.
module tb_note_sequencer;

  localparam int T  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          pause = 1'b0;
  logic          loop = 1'b0;
`ifdef NOTE_SEQ_REVERSE_EN
  logic          dir = 1'b0;
`endif
  logic [DW-1:0] divisor;
  logic          div_load;
  logic          div_enable;
  logic [2:0]    note_idx;
  logic          busy;
  logic          done;
  logic [1:0]    state_dbg;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] tbl [8];

  typedef struct {
    logic          start, stop, pause, loop;
    logic          busy, done, load, en;
    logic [2:0]    idx;
    logic [DW-1:0] div;
  } vec_t;
  vec_t vecs[13];

  note_sequencer #(.TEMPO_CYCLES(T), .DIV_W(DW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .stop(stop),
    .pause(pause),
    .loop(loop),
`ifdef NOTE_SEQ_REVERSE_EN
    .dir(dir),
`endif
    .divisor(divisor),
    .div_load(div_load),
    .div_enable(div_enable),
    .note_idx(note_idx),
    .busy(busy),
    .done(done),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: act=%0d req=%0d at %0t", name, act, req, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_vec(input int i, input logic s, input logic p, input logic pa,
                         input logic l, input logic b, input logic d, input logic ld,
                         input logic en, input logic [2:0] idx, input logic [DW-1:0] div);
    vecs[i].start = s;  vecs[i].stop = p;  vecs[i].pause = pa; vecs[i].loop = l;
    vecs[i].busy = b;   vecs[i].done = d;  vecs[i].load = ld;  vecs[i].en = en;
    vecs[i].idx = idx;  vecs[i].div = div;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_divisor"}, int'(divisor), 0);
    check({tag, "_load"}, int'(div_load), 0);
    check({tag, "_en"}, int'(div_enable), 0);
    check({tag, "_idx"}, int'(note_idx), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int ld_n;
    tbl[0] = 16'd47801; tbl[1] = 16'd42589; tbl[2] = 16'd37936; tbl[3] = 16'd35816;
    tbl[4] = 16'd31887; tbl[5] = 16'd28409; tbl[6] = 16'd25309; tbl[7] = 16'd23900;

    //          st sp pa lp  bsy dn ld en idx  div
    set_vec(0,  0, 0, 0, 0,  0,  0, 0, 0, 0, 16'd0);
    set_vec(1,  1, 1, 0, 0,  0,  0, 0, 0, 0, 16'd0);
    set_vec(2,  1, 0, 0, 0,  1,  0, 1, 0, 0, 16'd47801);
    set_vec(3,  1, 0, 0, 0,  1,  0, 0, 1, 0, 16'd47801);
    set_vec(4,  0, 0, 0, 0,  1,  0, 0, 1, 0, 16'd47801);
    set_vec(5,  0, 0, 0, 0,  1,  0, 0, 1, 0, 16'd47801);
    set_vec(6,  1, 0, 0, 0,  1,  0, 0, 1, 0, 16'd47801);
    set_vec(7,  0, 0, 0, 0,  1,  0, 1, 0, 1, 16'd42589);
    set_vec(8,  0, 0, 0, 0,  1,  0, 0, 1, 1, 16'd42589);
    set_vec(9,  0, 1, 0, 0,  0,  0, 0, 0, 1, 16'd42589);
    set_vec(10, 0, 0, 0, 0,  0,  0, 0, 0, 1, 16'd42589);
    set_vec(11, 1, 0, 0, 0,  1,  0, 1, 0, 0, 16'd47801);
    set_vec(12, 0, 1, 0, 0,  0,  0, 0, 0, 0, 16'd47801);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 13; i++) begin
      start = vecs[i].start; stop = vecs[i].stop;
      pause = vecs[i].pause; loop = vecs[i].loop;
      tick();
      check($sformatf("v%0d_busy", i), int'(busy), int'(vecs[i].busy));
      check($sformatf("v%0d_done", i), int'(done), int'(vecs[i].done));
      check($sformatf("v%0d_load", i), int'(div_load), int'(vecs[i].load));
      check($sformatf("v%0d_en", i), int'(div_enable), int'(vecs[i].en));
      check($sformatf("v%0d_idx", i), int'(note_idx), int'(vecs[i].idx));
      check($sformatf("v%0d_div", i), int'(divisor), int'(vecs[i].div));
    end
    start = 1'b0; stop = 1'b0; pause = 1'b0; loop = 1'b0;

    // full run, loop=0: eight loads 5 cycles apart, then DONE
    for (int k = 0; k < 8; k++) exp_q.push_back(tbl[k]);
    ld_n = 0;
    pulse_start();
    for (int c = 0; c <= 45; c++) begin
      if (c > 0) tick();
      if (div_load) begin
        if (exp_q.size() == 0) begin
          check("run_extra_load", c, -1);
        end else begin
          check("run_div", int'(divisor), int'(exp_q.pop_front()));
          check("run_off", c, ld_n * (T + 1));
          check("run_idx", int'(note_idx), ld_n);
          ld_n++;
        end
      end
      if (c == 39) check("run_done_early", int'(done), 0);
      if (c == 40) begin
        check("run_done", int'(done), 1);
        check("run_busy_done", int'(busy), 0);
      end
    end
    check("run_loads_left", exp_q.size(), 0);

    // loop=1 from DONE: wraps back to note 0 with busy held
    loop = 1'b1;
    pulse_start();
    check("loop_done_clr", int'(done), 0);
    check("loop_first_load", int'(div_load), 1);
    for (int c = 1; c <= 40; c++) begin
      tick();
      check($sformatf("loop_busy_c%0d", c), int'(busy), 1);
      if (c == 35) check("loop_last_div", int'(divisor), int'(tbl[7]));
    end
    check("loop_wrap_load", int'(div_load), 1);
    check("loop_wrap_idx", int'(note_idx), 0);
    check("loop_wrap_div", int'(divisor), int'(tbl[0]));
    loop = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("loop_stop_busy", int'(busy), 0);
    check("loop_stop_en", int'(div_enable), 0);

    // pause for 3 cycles in PLAY of note 2
    pulse_start();
    advance(11);
    check("pause_pre_en", int'(div_enable), 1);
    pause = 1'b1;
    for (int c = 12; c <= 14; c++) begin
      tick();
      check($sformatf("pause_en_c%0d", c), int'(div_enable), 0);
      check($sformatf("pause_div_c%0d", c), int'(divisor), int'(tbl[2]));
    end
    pause = 1'b0;
    tick();
    check("pause_resume_en", int'(div_enable), 1);
    check("pause_no_early_load", int'(div_load), 0);
    advance(2);
    check("pause_c17_load", int'(div_load), 0);
    tick();
    check("pause_late_load", int'(div_load), 1);
    check("pause_late_div", int'(divisor), int'(tbl[3]));
    check("pause_late_idx", int'(note_idx), 3);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // stop coincident with terminal count of note 4
    pulse_start();
    advance(24);
    check("stop_pre_idx", int'(note_idx), 4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_load", int'(div_load), 0);
    check("stop_busy", int'(busy), 0);
    check("stop_en", int'(div_enable), 0);
    check("stop_done", int'(done), 0);
    check("stop_idx", int'(note_idx), 4);
    check("stop_div", int'(divisor), int'(tbl[4]));
    tick();
    check("stop_stays_idle", int'(div_load), 0);

    // asynchronous reset mid-PLAY of note 5
    pulse_start();
    advance(27);
    check("rst_pre_idx", int'(note_idx), 5);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_zero("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    pulse_start();
    check("rst_restart_load", int'(div_load), 1);
    check("rst_restart_idx", int'(note_idx), 0);
    check("rst_restart_div", int'(divisor), int'(tbl[0]));
    stop = 1'b1;
    tick();
    stop = 1'b0;

`ifdef NOTE_SEQ_REVERSE_EN
    // descending run: dir is only sampled when start is accepted
    dir = 1'b1;
    pulse_start();
    dir = 1'b0;
    check("rev_first_div", int'(divisor), int'(tbl[7]));
    check("rev_first_idx", int'(note_idx), 7);
    advance(5);
    check("rev_second_idx", int'(note_idx), 6);
    advance(30);
    check("rev_last_load", int'(div_load), 1);
    check("rev_last_idx", int'(note_idx), 0);
    check("rev_last_div", int'(divisor), int'(tbl[0]));
    advance(5);
    check("rev_done", int'(done), 1);
`endif

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
